// File: rtl/gbe_tx_frame_arbiter_if.sv
// LocalLink bundle between the client tx FIFOs and the EMAC tx client port.
// The master modport is the arbiter's view; slave is the FIFO/EMAC side.
interface gbe_tx_frame_arbiter_if #(
    parameter int NUM_SRC = 3
);
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_sof_n;
    logic [NUM_SRC-1:0]   src_eof_n;
    logic [NUM_SRC-1:0]   src_src_rdy_n;
    logic [NUM_SRC-1:0]   src_dst_rdy_n;
    logic [7:0]           tx_data;
    logic                 tx_sof_n;
    logic                 tx_eof_n;
    logic                 tx_src_rdy_n;
    logic                 tx_dst_rdy_n;

    modport master (
        input  src_data, src_sof_n, src_eof_n, src_src_rdy_n, tx_dst_rdy_n,
        output src_dst_rdy_n, tx_data, tx_sof_n, tx_eof_n, tx_src_rdy_n
    );

    modport slave (
        output src_data, src_sof_n, src_eof_n, src_src_rdy_n, tx_dst_rdy_n,
        input  src_dst_rdy_n, tx_data, tx_sof_n, tx_eof_n, tx_src_rdy_n
    );
endinterface

// File: rtl/gbe_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the EMAC tx LocalLink port among client FIFOs.
// Optional mid-frame stall watchdog is enabled by defining TX_WATCHDOG_EN.
module gbe_tx_frame_arbiter #(
    parameter int          NUM_SRC = 3,
    parameter logic [3:0]  GAP_CYC = 4'd2,
    parameter logic [15:0] TIMEOUT = 16'd2047
) (
    input  logic                  tx_clk,
    input  logic                  reset,
    gbe_tx_frame_arbiter_if.master bus,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  abort_pulse
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
`ifdef TX_WATCHDOG_EN
    localparam logic [1:0] ST_DRAIN = 2'd3;
`endif
    localparam logic [1:0] LAST_SRC  = 2'(NUM_SRC - 1);
    localparam logic [2:0] NUM_SRC_W = 3'(NUM_SRC);

    logic [1:0] state;
    logic [1:0] rr_ptr;
    logic [3:0] gap_cnt;
    logic [3:0] req_pad;
    logic       req_found;
    logic [1:0] req_idx;
    logic [2:0] scan_idx;
    logic [7:0] sel_data;
    logic       sel_sof_n;
    logic       sel_eof_n;
    logic       sel_rdy_n;
    logic       beat;
    logic       eof_beat;
    logic       term_active;
    logic [1:0] rr_next;
    logic [1:0] done_state;

    assign req_pad = 4'(~bus.src_src_rdy_n & ~bus.src_sof_n);

    // Scan from the round-robin pointer; the first SOF requester wins.
    always_comb begin
        req_found = 1'b0;
        req_idx   = rr_ptr;
        scan_idx  = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_idx = {1'b0, rr_ptr} + 3'(i);
            if (scan_idx >= NUM_SRC_W) scan_idx = scan_idx - NUM_SRC_W;
            if (!req_found && req_pad[scan_idx[1:0]]) begin
                req_found = 1'b1;
                req_idx   = scan_idx[1:0];
            end
        end
    end

    always_comb begin
        sel_data  = 8'h00;
        sel_sof_n = 1'b1;
        sel_eof_n = 1'b1;
        sel_rdy_n = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_id == 2'(k)) begin
                sel_data  = bus.src_data[8*k +: 8];
                sel_sof_n = bus.src_sof_n[k];
                sel_eof_n = bus.src_eof_n[k];
                sel_rdy_n = bus.src_src_rdy_n[k];
            end
        end
    end

    assign beat       = (state == ST_XFER) && !term_active && !sel_rdy_n && !bus.tx_dst_rdy_n;
    assign eof_beat   = beat && !sel_eof_n;
    assign rr_next    = (grant_id == LAST_SRC) ? 2'd0 : grant_id + 2'd1;
    assign done_state = (GAP_CYC == 4'd0) ? ST_IDLE : ST_GAP;
    assign busy       = (state != ST_IDLE);

    // Pass-through is purely combinational so the first beat goes out the cycle after the grant.
    always_comb begin
        bus.tx_data       = 8'h00;
        bus.tx_sof_n      = 1'b1;
        bus.tx_eof_n      = 1'b1;
        bus.tx_src_rdy_n  = 1'b1;
        bus.src_dst_rdy_n = '1;
        if (state == ST_XFER) begin
            if (term_active) begin
                bus.tx_eof_n     = 1'b0;
                bus.tx_src_rdy_n = 1'b0;
            end else begin
                bus.tx_data      = sel_data;
                bus.tx_sof_n     = sel_sof_n;
                bus.tx_eof_n     = sel_eof_n;
                bus.tx_src_rdy_n = sel_rdy_n;
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (grant_id == 2'(k)) bus.src_dst_rdy_n[k] = bus.tx_dst_rdy_n;
                end
            end
        end
`ifdef TX_WATCHDOG_EN
        else if (state == ST_DRAIN) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (grant_id == 2'(k)) bus.src_dst_rdy_n[k] = 1'b0;
            end
        end
`endif
    end

`ifdef TX_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        term_hold;
    logic        abort_accept;
    logic        drain_eof;

    // A source beat presented in the limit cycle wins; once shown, the terminator is held until taken.
    assign term_active  = (state == ST_XFER) && (term_hold || ((wd_cnt == TIMEOUT) && sel_rdy_n));
    assign abort_accept = term_active && !bus.tx_dst_rdy_n;
    assign drain_eof    = (state == ST_DRAIN) && !sel_rdy_n && !sel_eof_n;

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= 16'd0;
            term_hold   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= abort_accept;
            term_hold   <= term_active && !abort_accept;
            if (state != ST_XFER || beat) begin
                wd_cnt <= 16'd0;
            end else if (sel_rdy_n && !bus.tx_dst_rdy_n && wd_cnt != TIMEOUT) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end
`else
    assign term_active = 1'b0;
    assign abort_pulse = 1'b0;
`endif

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= 2'd0;
            grant_id <= 2'd0;
            gap_cnt  <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_found) begin
                        grant_id <= req_idx;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eof_beat) begin
                        rr_ptr  <= rr_next;
                        gap_cnt <= 4'd0;
                        state   <= done_state;
                    end
`ifdef TX_WATCHDOG_EN
                    else if (abort_accept) begin
                        state <= ST_DRAIN;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt >= GAP_CYC - 4'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
`ifdef TX_WATCHDOG_EN
                ST_DRAIN: begin
                    if (drain_eof) begin
                        rr_ptr  <= rr_next;
                        gap_cnt <= 4'd0;
                        state   <= done_state;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gbe_tx_frame_arbiter.sv
// Directed bench for gbe_tx_frame_arbiter: main instance with GAP_CYC=2, second with GAP_CYC=0.
// The watchdog scenario is compiled in only when TX_WATCHDOG_EN is defined.
module tb_gbe_tx_frame_arbiter;
    logic       tx_clk;
    logic       reset;
    logic [1:0] grant_id, grant_id_b;
    logic       busy, busy_b;
    logic       abort_pulse, abort_pulse_b;

    gbe_tx_frame_arbiter_if #(.NUM_SRC(3)) bus ();
    gbe_tx_frame_arbiter_if #(.NUM_SRC(3)) bus_b ();

    gbe_tx_frame_arbiter #(.NUM_SRC(3), .GAP_CYC(4'd2), .TIMEOUT(16'd8)) u_dut (
        .tx_clk(tx_clk), .reset(reset), .bus(bus),
        .grant_id(grant_id), .busy(busy), .abort_pulse(abort_pulse)
    );

    gbe_tx_frame_arbiter #(.NUM_SRC(3), .GAP_CYC(4'd0), .TIMEOUT(16'd8)) u_dut_b (
        .tx_clk(tx_clk), .reset(reset), .bus(bus_b),
        .grant_id(grant_id_b), .busy(busy_b), .abort_pulse(abort_pulse_b)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sof_n;
        logic       eof_n;
    } beat_t;

    beat_t txq[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    s_len[3], s_pos[3], s_frames[3], s_frame_len[3];
    bit    s_pause[3];
    bit    emac_stall;
    bit    abort_seen;
    int    cyc;

    logic [1:0] snap_grant;
    logic       snap_busy, snap_abort;
    logic [2:0] snap_dst;
    logic [7:0] snap_tx_data;
    logic       snap_tx_sof_n, snap_tx_eof_n, snap_tx_rdy_n;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < 3; k++) begin
            bus.src_src_rdy_n[k]   = !(s_len[k] != 0 && !s_pause[k]);
            bus.src_sof_n[k]       = !(s_pos[k] == 0);
            bus.src_eof_n[k]       = !(s_len[k] == 1);
            bus.src_data[8*k +: 8] = 8'(k*64 + s_pos[k]);
        end
        bus.tx_dst_rdy_n = emac_stall;
    endtask

    task automatic startFrame(input int k, input int len, input int frames);
        s_len[k]       = len;
        s_pos[k]       = 0;
        s_frame_len[k] = len;
        s_frames[k]    = frames - 1;
    endtask

    // Snapshot at the falling edge, then advance the source models past the rising edge.
    task automatic stepCycle();
        bit hs[3];
        @(negedge tx_clk);
        snap_grant    = grant_id;
        snap_busy     = busy;
        snap_abort    = abort_pulse;
        snap_dst      = bus.src_dst_rdy_n;
        snap_tx_data  = bus.tx_data;
        snap_tx_sof_n = bus.tx_sof_n;
        snap_tx_eof_n = bus.tx_eof_n;
        snap_tx_rdy_n = bus.tx_src_rdy_n;
        if (abort_pulse) abort_seen = 1'b1;
        for (int k = 0; k < 3; k++) hs[k] = !bus.src_src_rdy_n[k] && !bus.src_dst_rdy_n[k];
        if (!bus.tx_src_rdy_n && !bus.tx_dst_rdy_n)
            txq.push_back({bus.tx_data, bus.tx_sof_n, bus.tx_eof_n});
        @(posedge tx_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (hs[k]) begin
                s_pos[k]++;
                s_len[k]--;
                if (s_len[k] == 0 && s_frames[k] > 0) begin
                    s_frames[k]--;
                    s_len[k] = s_frame_len[k];
                    s_pos[k] = 0;
                end
            end
        end
        applyStimulus();
    endtask

    task automatic runUntil(input int beats, input int limit);
        cyc = 0;
        while (txq.size() < beats && cyc < limit) begin
            stepCycle();
            cyc++;
        end
    endtask

    function automatic int frameErrs(input int off, input int src, input int cnt, input int len);
        int errs = 0;
        for (int i = 0; i < cnt; i++) begin
            if (off + i >= txq.size()) errs++;
            else if (txq[off+i].data !== 8'(src*64 + i) || txq[off+i].sof_n !== (i != 0) ||
                     txq[off+i].eof_n !== (i != len - 1)) errs++;
        end
        return errs;
    endfunction

    initial begin
        reset = 1'b1;
        emac_stall = 1'b0;
        abort_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_len[k] = 0; s_pos[k] = 0; s_frames[k] = 0; s_frame_len[k] = 0; s_pause[k] = 0;
        end
        applyStimulus();
        bus_b.src_data = '0;
        bus_b.src_sof_n = 3'b111;
        bus_b.src_eof_n = 3'b111;
        bus_b.src_src_rdy_n = 3'b111;
        bus_b.tx_dst_rdy_n = 1'b0;

        repeat (3) @(posedge tx_clk);
        @(negedge tx_clk);
        checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h00);
        checkOutput("rst_tx_sof", 32'(bus.tx_sof_n), 32'd1);
        checkOutput("rst_tx_eof", 32'(bus.tx_eof_n), 32'd1);
        checkOutput("rst_tx_rdy", 32'(bus.tx_src_rdy_n), 32'd1);
        checkOutput("rst_dst_rdy", 32'(bus.src_dst_rdy_n), 32'h7);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_abort", 32'(abort_pulse), 32'd0);
        @(posedge tx_clk);
        #1;
        reset = 1'b0;

        $display("[TB] single 60-byte frame from source 1");
        startFrame(1, 60, 1);
        applyStimulus();
        runUntil(60, 200);
        checkOutput("t1_beats", 32'(txq.size()), 32'd60);
        checkOutput("t1_seq_errs", 32'(frameErrs(0, 1, 60, 60)), 32'd0);
        checkOutput("t1_grant", 32'(snap_grant), 32'd1);
        startFrame(2, 1, 1);
        applyStimulus();
        stepCycle();
        checkOutput("gap1_busy", 32'(snap_busy), 32'd1);
        checkOutput("gap1_dst", 32'(snap_dst), 32'h7);
        stepCycle();
        checkOutput("gap2_dst", 32'(snap_dst), 32'h7);
        checkOutput("gap2_tx_rdy", 32'(snap_tx_rdy_n), 32'd1);
        stepCycle();
        checkOutput("gap_idle_busy", 32'(snap_busy), 32'd0);
        stepCycle();
        checkOutput("gap_grant_dst", 32'(snap_dst), 32'h3);
        checkOutput("gap_grant_id", 32'(snap_grant), 32'd2);

        $display("[TB] three sources, round robin");
        txq.delete();
        startFrame(0, 10, 2);
        startFrame(1, 10, 2);
        startFrame(2, 10, 2);
        applyStimulus();
        runUntil(60, 600);
        checkOutput("t2_beats", 32'(txq.size()), 32'd60);
        for (int f = 0; f < 6; f++) begin
            checkOutput("t2_order", 32'(frameErrs(f*10, f % 3, 10, 10)), 32'd0);
        end

        $display("[TB] EMAC back-pressure at beat 20");
        txq.delete();
        abort_seen = 1'b0;
        startFrame(0, 40, 1);
        applyStimulus();
        runUntil(19, 100);
        emac_stall = 1'b1;
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("t3_hold_dst", 32'(snap_dst[0]), 32'd1);
            checkOutput("t3_hold_data", 32'(snap_tx_data), 32'd19);
        end
        checkOutput("t3_frozen", 32'(txq.size()), 32'd19);
        emac_stall = 1'b0;
        applyStimulus();
        runUntil(40, 100);
        checkOutput("t3_seq_errs", 32'(frameErrs(0, 0, 40, 40)), 32'd0);
        checkOutput("t3_abort", 32'(abort_seen), 32'd0);

        $display("[TB] asynchronous reset at beat 30 of source 2");
        txq.delete();
        startFrame(2, 60, 1);
        applyStimulus();
        runUntil(29, 200);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4_tx_rdy", 32'(bus.tx_src_rdy_n), 32'd1);
        checkOutput("t4_tx_data", 32'(bus.tx_data), 32'h00);
        checkOutput("t4_tx_eof", 32'(bus.tx_eof_n), 32'd1);
        checkOutput("t4_dst", 32'(bus.src_dst_rdy_n), 32'h7);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_grant", 32'(grant_id), 32'd0);
        for (int k = 0; k < 3; k++) begin
            s_len[k] = 0; s_pos[k] = 0; s_frames[k] = 0;
        end
        applyStimulus();
        @(posedge tx_clk);
        #1;
        reset = 1'b0;
        txq.delete();
        startFrame(0, 5, 1);
        startFrame(2, 5, 1);
        applyStimulus();
        runUntil(10, 100);
        checkOutput("t4_first_src0", 32'(frameErrs(0, 0, 5, 5)), 32'd0);
        checkOutput("t4_then_src2", 32'(frameErrs(5, 2, 5, 5)), 32'd0);

`ifdef TX_WATCHDOG_EN
        $display("[TB] watchdog abort on stalled source 0");
        txq.delete();
        abort_seen = 1'b0;
        startFrame(0, 20, 1);
        applyStimulus();
        runUntil(10, 100);
        s_pause[0] = 1'b1;
        applyStimulus();
        cyc = 0;
        do begin
            stepCycle();
            cyc++;
        end while (!(snap_tx_eof_n == 1'b0 && snap_tx_rdy_n == 1'b0) && cyc < 30);
        checkOutput("t5_stall_cycles", 32'(cyc), 32'd9);
        checkOutput("t5_term_data", 32'(snap_tx_data), 32'h00);
        stepCycle();
        checkOutput("t5_abort_pulse", 32'(snap_abort), 32'd1);
        checkOutput("t5_drain_tx_rdy", 32'(snap_tx_rdy_n), 32'd1);
        s_pause[0] = 1'b0;
        startFrame(1, 3, 1);
        applyStimulus();
        runUntil(14, 100);
        checkOutput("t5_head_errs", 32'(frameErrs(0, 0, 10, 20)), 32'd0);
        checkOutput("t5_term_beat", 32'(txq.size() > 10 ? {txq[10].data, txq[10].eof_n} : 9'h1FF), 32'd0);
        checkOutput("t5_next_src1", 32'(txq.size() > 11 ? txq[11].data : 8'hFF), 32'd64);
        checkOutput("t5_drained", 32'(s_len[0]), 32'd0);
`endif

        $display("[TB] GAP_CYC=0 back-to-back arbitration");
        bus_b.src_data = {8'hA5, 8'h00, 8'h00};
        bus_b.src_src_rdy_n = 3'b011;
        bus_b.src_sof_n = 3'b011;
        bus_b.src_eof_n = 3'b011;
        @(posedge tx_clk);
        #1;
        bus_b.src_data = {8'hA5, 8'h00, 8'h11};
        bus_b.src_src_rdy_n = 3'b010;
        bus_b.src_sof_n = 3'b010;
        bus_b.src_eof_n = 3'b010;
        @(negedge tx_clk);
        checkOutput("t6_xfer_grant", 32'(grant_id_b), 32'd2);
        checkOutput("t6_xfer_data", 32'(bus_b.tx_data), 32'hA5);
        checkOutput("t6_xfer_eof", 32'(bus_b.tx_eof_n), 32'd0);
        checkOutput("t6_xfer_dst", 32'(bus_b.src_dst_rdy_n), 32'h3);
        @(posedge tx_clk);
        #1;
        bus_b.src_src_rdy_n = 3'b110;
        bus_b.src_sof_n = 3'b110;
        bus_b.src_eof_n = 3'b110;
        @(negedge tx_clk);
        checkOutput("t6_idle_busy", 32'(busy_b), 32'd0);
        checkOutput("t6_idle_tx_rdy", 32'(bus_b.tx_src_rdy_n), 32'd1);
        @(posedge tx_clk);
        #1;
        @(negedge tx_clk);
        checkOutput("t6_src0_busy", 32'(busy_b), 32'd1);
        checkOutput("t6_src0_grant", 32'(grant_id_b), 32'd0);
        checkOutput("t6_src0_dst", 32'(bus_b.src_dst_rdy_n), 32'h6);
        checkOutput("t6_src0_data", 32'(bus_b.tx_data), 32'h11);
        @(posedge tx_clk);
        #1;
        bus_b.src_src_rdy_n = 3'b111;
        bus_b.src_sof_n = 3'b111;
        bus_b.src_eof_n = 3'b111;
        @(negedge tx_clk);
        checkOutput("t6_done_busy", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
